// File: rtl/dsp_elastic_pipe.sv
// Purpose: DEPTH-stage elastic register pipe with valid/ready, bubble collapsing, ce, flush and occupancy count.
// Latency: DEPTH cycles from accept to out_valid when unstalled; DEPTH=0 is a combinational passthrough.
// Backpressure: in_ready is a combinational chain from out_ready through any bubble; full pipe holds indefinitely.
module dsp_elastic_pipe #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2,
    localparam int CNT_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    generate
        if (DEPTH == 0) begin : g_pass
            // No storage at all: clk and rst are deliberately left dangling.
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst};

            assign out_data  = in_data;
            assign out_valid = in_valid & ce & ~flush;
            assign in_ready  = out_ready & ce & ~flush;
            assign count     = '0;
        end else begin : g_pipe
            logic             go;
            logic [DEPTH-1:0] adv;
            logic [DEPTH-1:0] vld_q;
            logic [WIDTH-1:0] data_q   [DEPTH];
            logic [DEPTH-1:0] pred_vld;
            logic [WIDTH-1:0] pred_dat [DEPTH];
            logic [CNT_W-1:0] cnt_q;
            logic             in_hs;
            logic             out_hs;

            assign go = ce & ~flush;

            // A stage advances when it is empty or everything ahead of it drains; this is
            // the flattened form of the per-stage ready chain, so no stage refers to itself.
            always_comb begin
                logic tail;
                adv  = '0;
                tail = out_ready;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    tail   = tail | ~vld_q[i];
                    adv[i] = go & tail;
                end
            end

            // Each stage's upstream source: the producer for stage 0, the previous stage otherwise.
            always_comb begin
                pred_vld[0] = in_valid;
                pred_dat[0] = in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    pred_vld[i] = vld_q[i-1];
                    pred_dat[i] = data_q[i-1];
                end
            end

            assign in_ready  = adv[0];
            assign out_valid = vld_q[DEPTH-1] & go;
            assign out_data  = data_q[DEPTH-1];
            assign count     = cnt_q;
            assign in_hs     = in_valid & adv[0];
            assign out_hs    = out_valid & out_ready;

            // Stage registers: flush drops valids only; data moves only with a valid beat.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                end else if (ce && flush) begin
                    vld_q <= '0;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (adv[i]) begin
                            vld_q[i] <= pred_vld[i];
                            if (pred_vld[i]) begin
                                data_q[i] <= pred_dat[i];
                            end
                        end
                    end
                end
            end

            // Occupancy tracks handshakes so it always matches the number of valid stages.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (ce && flush) begin
                    cnt_q <= '0;
                end else if (in_hs && !out_hs) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if (out_hs && !in_hs) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule
